spdif_tx: RTL and testbench

//  S/PDIF (IEC 60958 consumer) transmitter: serialises stereo 24-bit PCM plus per-block user and channel-status bits into a biphase-mark line signal.

---
 rtl/spdif_pkg.sv | 35 +++
 rtl/spdif_tx_bmc_serializer.sv | 68 ++++++
 rtl/spdif_tx.sv | 136 +++++++++++++
 tb/tb_spdif_tx.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/spdif_pkg.sv
// Shared S/PDIF framing constants and helpers (also used by spdif_dai).
package spdif_pkg;

    localparam logic [7:0] SYNCCODE_B = 8'b00010111;
    localparam logic [7:0] SYNCCODE_M = 8'b00011101;
    localparam logic [7:0] SYNCCODE_W = 8'b00011011;

    localparam int unsigned SUBFRAME_SLOTS   = 32;
    localparam int unsigned FRAMES_PER_BLOCK = 192;

    localparam int unsigned SLOT_AUDIO_FIRST = 4;
    localparam int unsigned SLOT_V           = 28;
    localparam int unsigned SLOT_U           = 29;
    localparam int unsigned SLOT_C           = 30;
    localparam int unsigned SLOT_P           = 31;

    typedef enum logic [1:0] {
        PreB,
        PreM,
        PreW
    } preamble_e;

    // Sync code in its "line level was 1" form.
    function automatic logic [7:0] preamble_code(input preamble_e kind);
        logic [7:0] code;
        case (kind)
            PreB:    code = SYNCCODE_B;
            PreM:    code = SYNCCODE_M;
            PreW:    code = SYNCCODE_W;
            default: code = SYNCCODE_M;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/spdif_tx_bmc_serializer.sv
// Halfbit timer and biphase-mark line register.
// Emits one subbit per tick; the caller supplies what the next subbit should encode.
module spdif_tx_bmc_serializer #(
    parameter int unsigned MAX_CLK_PER_HALFBIT_LOG2 = 5
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [MAX_CLK_PER_HALFBIT_LOG2-1:0] clk_per_halfbit,
    input  logic                                is_preamble_i,
    input  logic [7:0]                          preamble_code_i,
    input  logic [2:0]                          preamble_idx_i,
    input  logic                                second_half_i,
    input  logic                                data_bit_i,
    output logic                                signal_o,
    output logic                                tick_o
);

    logic [MAX_CLK_PER_HALFBIT_LOG2-1:0] r_cnt;
    logic [MAX_CLK_PER_HALFBIT_LOG2-1:0] r_period;
    logic                                r_signal;
    logic                                r_pre_inv;

    logic w_tick;
    logic w_inv;
    logic w_next;

    // Period is latched at each tick, so a mid-subbit change never shortens the subbit.
    assign w_tick = (r_cnt == r_period);

    // Next subbit: preamble code (polarity fixed by level at preamble start) or BMC data half.
    always_comb begin
        w_inv  = r_pre_inv;
        w_next = r_signal;
        if (preamble_idx_i == 3'd0) begin
            w_inv = ~r_signal;
        end
        if (is_preamble_i) begin
            w_next = preamble_code_i[3'd7 - preamble_idx_i] ^ w_inv;
        end else if (!second_half_i) begin
            w_next = ~r_signal;
        end else begin
            w_next = data_bit_i ? ~r_signal : r_signal;
        end
    end

    // Timer, line level and preamble polarity.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_period  <= '0;
            r_signal  <= 1'b0;
            r_pre_inv <= 1'b0;
        end else if (w_tick) begin
            r_cnt    <= '0;
            r_period <= clk_per_halfbit;
            r_signal <= w_next;
            if (is_preamble_i && (preamble_idx_i == 3'd0)) begin
                r_pre_inv <= w_inv;
            end
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign signal_o = r_signal;
    assign tick_o   = w_tick;

endmodule

// File: rtl/spdif_tx.sv
// S/PDIF consumer transmitter: frames stereo 24-bit PCM with V/U/C/P bits into
// 192-frame blocks and hands each subbit to the BMC serializer.
module spdif_tx
    import spdif_pkg::*;
#(
    parameter int unsigned MAX_CLK_PER_HALFBIT_LOG2 = 5
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [MAX_CLK_PER_HALFBIT_LOG2-1:0] clk_per_halfbit,
    input  logic [23:0]                         data_l_i,
    input  logic [23:0]                         data_r_i,
    input  logic                                valid_i,
    output logic                                pop_o,
    input  logic [191:0]                        udata_i,
    input  logic [191:0]                        cdata_i,
    output logic                                signal_o,
    output logic                                lrck_o,
    output logic                                underrun_o
);

    localparam logic [5:0] LastSubbit = 6'(2 * SUBFRAME_SLOTS - 1);
    localparam logic [7:0] LastFrame  = 8'(FRAMES_PER_BLOCK - 1);

    // r_sub is the index of the subbit loaded at the next tick.
    logic [5:0]   r_sub;
    logic         r_right;
    logic [7:0]   r_frame;
    logic         r_lrck;
    logic [23:0]  r_l;
    logic [23:0]  r_r;
    logic         r_v;
    logic [191:0] r_ushadow;
    logic [191:0] r_cshadow;

    logic         w_tick;
    logic         w_left_start;
    logic         w_block_start;
    logic [4:0]   w_slot;
    logic [4:0]   w_audio_idx;
    logic [7:0]   w_blk_idx;
    logic [23:0]  w_sample;
    logic         w_u;
    logic         w_c;
    logic         w_parity;
    logic         w_data_bit;
    logic         w_is_preamble;
    logic [7:0]   w_code;

    assign w_slot        = r_sub[5:1];
    assign w_is_preamble = (r_sub[5:3] == 3'd0);
    assign w_left_start  = w_tick & (r_sub == 6'd0) & ~r_right;
    assign w_block_start = w_left_start & (r_frame == 8'd0);

    assign w_sample  = r_right ? r_r : r_l;
    assign w_blk_idx = LastFrame - r_frame;
    assign w_u       = r_ushadow[w_blk_idx];
    assign w_c       = r_cshadow[w_blk_idx];
    // Even parity over audio+V+U+C keeps the subframe end level equal to its start level.
    assign w_parity  = ^{w_sample, r_v, w_u, w_c};
    assign w_code    = preamble_code(r_right ? PreW : ((r_frame == 8'd0) ? PreB : PreM));

    // Select the bit carried by the current data slot.
    always_comb begin
        w_data_bit  = 1'b0;
        w_audio_idx = w_slot - 5'(SLOT_AUDIO_FIRST);
        case (w_slot)
            5'(SLOT_V): w_data_bit = r_v;
            5'(SLOT_U): w_data_bit = w_u;
            5'(SLOT_C): w_data_bit = w_c;
            5'(SLOT_P): w_data_bit = w_parity;
            default: begin
                if (w_slot >= 5'(SLOT_AUDIO_FIRST)) begin
                    w_data_bit = w_sample[w_audio_idx];
                end
            end
        endcase
    end

    spdif_tx_bmc_serializer #(
        .MAX_CLK_PER_HALFBIT_LOG2(MAX_CLK_PER_HALFBIT_LOG2)
    ) u_bmc (
        .clk             (clk),
        .rst_n           (rst_n),
        .clk_per_halfbit (clk_per_halfbit),
        .is_preamble_i   (w_is_preamble),
        .preamble_code_i (w_code),
        .preamble_idx_i  (r_sub[2:0]),
        .second_half_i   (r_sub[0]),
        .data_bit_i      (w_data_bit),
        .signal_o        (signal_o),
        .tick_o          (w_tick)
    );

    // Subbit/subframe/frame counters, sample capture and block shadow registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sub     <= '0;
            r_right   <= 1'b0;
            r_frame   <= '0;
            r_lrck    <= 1'b0;
            r_l       <= '0;
            r_r       <= '0;
            r_v       <= 1'b0;
            r_ushadow <= '0;
            r_cshadow <= '0;
        end else if (w_tick) begin
            r_sub <= r_sub + 1'b1;
            if (r_sub == LastSubbit) begin
                r_right <= ~r_right;
                if (r_right) begin
                    r_frame <= (r_frame == LastFrame) ? 8'd0 : r_frame + 1'b1;
                end
            end
            if (r_sub == 6'd0) begin
                r_lrck <= r_right;
            end
            if (w_left_start) begin
                // Underrun sends silence flagged invalid in both subframes.
                r_l <= valid_i ? data_l_i : 24'd0;
                r_r <= valid_i ? data_r_i : 24'd0;
                r_v <= ~valid_i;
            end
            if (w_block_start) begin
                r_ushadow <= udata_i;
                r_cshadow <= cdata_i;
            end
        end
    end

    // Handshake strobes are combinational so upstream can dequeue on this same edge.
    assign pop_o      = rst_n & w_left_start & valid_i;
    assign underrun_o = rst_n & w_left_start & ~valid_i;
    assign lrck_o     = r_lrck;

endmodule

// File: tb/tb_spdif_tx.sv
// Self-checking bench for spdif_tx against a frame-level reference model.
module tb_spdif_tx;

    localparam int N = 5;
    localparam logic [7:0] CODE_B = 8'b00010111;
    localparam logic [7:0] CODE_M = 8'b00011101;
    localparam logic [7:0] CODE_W = 8'b00011011;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   clk_per_halfbit;
    logic [23:0]    data_l_i;
    logic [23:0]    data_r_i;
    logic           valid_i;
    logic           pop_o;
    logic [191:0]   udata_i;
    logic [191:0]   cdata_i;
    logic           signal_o;
    logic           lrck_o;
    logic           underrun_o;

    spdif_tx #(
        .MAX_CLK_PER_HALFBIT_LOG2(N)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .clk_per_halfbit (clk_per_halfbit),
        .data_l_i        (data_l_i),
        .data_r_i        (data_r_i),
        .valid_i         (valid_i),
        .pop_o           (pop_o),
        .udata_i         (udata_i),
        .cdata_i         (cdata_i),
        .signal_o        (signal_o),
        .lrck_o          (lrck_o),
        .underrun_o      (underrun_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic         fr_bits [0:127];
    logic [191:0] sh_u;
    logic [191:0] sh_c;
    logic         m_sig;
    logic         m_lrck;
    int           m_cyc;
    int           m_len;
    int           m_sub_g;
    int           m_frame;
    int           n_frames;
    int           pops_seen;
    logic         last_sig;
    bit           jitter;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One subframe as 64 subbits, built from slot rules and a running line level.
    task automatic make_sub(input logic [7:0] code, input logic [23:0] aud, input logic v,
                            input logic u, input logic c, input int base, inout logic lvl);
        logic slots [0:31];
        logic first;
        for (int i = 0; i < 32; i++) slots[i] = 1'b0;
        for (int i = 0; i < 24; i++) slots[4 + i] = aud[i];
        slots[28] = v;
        slots[29] = u;
        slots[30] = c;
        slots[31] = logic'($countones({aud, v, u, c}) % 2);
        for (int k = 0; k < 8; k++) fr_bits[base + k] = lvl ? code[7 - k] : ~code[7 - k];
        lvl = fr_bits[base + 7];
        for (int s = 4; s < 32; s++) begin
            first = ~lvl;
            fr_bits[base + 2 * s]     = first;
            fr_bits[base + 2 * s + 1] = slots[s] ? ~first : first;
            lvl = fr_bits[base + 2 * s + 1];
        end
    endtask

    task automatic build_frame();
        logic [23:0] al;
        logic [23:0] ar;
        logic        lvl;
        logic        u;
        logic        c;
        if (m_frame == 0) begin
            sh_u = udata_i;
            sh_c = cdata_i;
        end
        al  = valid_i ? data_l_i : 24'd0;
        ar  = valid_i ? data_r_i : 24'd0;
        u   = sh_u[191 - m_frame];
        c   = sh_c[191 - m_frame];
        lvl = m_sig;
        make_sub((m_frame == 0) ? CODE_B : CODE_M, al, ~valid_i, u, c, 0, lvl);
        make_sub(CODE_W, ar, ~valid_i, u, c, 64, lvl);
        m_frame = (m_frame + 1) % 192;
    endtask

    task automatic next_inputs();
        n_frames++;
        valid_i  = (n_frames % 7 != 3);
        data_l_i = 24'($urandom);
        data_r_i = 24'($urandom);
        if (m_frame == 1) begin
            udata_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            cdata_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        end
    endtask

    // One clock: check outputs at negedge, advance model, then drive inputs after posedge.
    task automatic cycle();
        logic tick;
        logic fstart;
        int   idx;
        @(negedge clk);
        last_sig = signal_o;
        chk("signal", 32'(signal_o), 32'(m_sig));
        chk("lrck", 32'(lrck_o), 32'(m_lrck));
        tick   = (m_cyc == m_len - 1);
        fstart = tick && (m_sub_g % 128 == 0);
        chk("pop", 32'(pop_o), 32'(fstart && valid_i));
        chk("underrun", 32'(underrun_o), 32'(fstart && !valid_i));
        if (pop_o === 1'b1) pops_seen++;
        if (fstart) build_frame();
        if (tick) begin
            idx     = m_sub_g % 128;
            m_sig   = fr_bits[idx];
            m_lrck  = (idx >= 64);
            m_len   = int'(clk_per_halfbit) + 1;
            m_cyc   = 0;
            m_sub_g = m_sub_g + 1;
        end else begin
            m_cyc++;
        end
        @(posedge clk);
        #1;
        if (fstart) next_inputs();
        if (jitter && ($urandom_range(0, 40) == 0)) clk_per_halfbit = N'($urandom_range(0, 5));
    endtask

    task automatic do_reset(input int ncyc);
        rst_n = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            chk("rst_pop", 32'(pop_o), 32'd0);
            chk("rst_underrun", 32'(underrun_o), 32'd0);
            if (k > 0) begin
                chk("rst_signal", 32'(signal_o), 32'd0);
                chk("rst_lrck", 32'(lrck_o), 32'd0);
            end
            @(posedge clk);
            #1;
        end
        m_sig   = 1'b0;
        m_lrck  = 1'b0;
        m_cyc   = 0;
        m_len   = 1;
        m_sub_g = 0;
        m_frame = 0;
        rst_n   = 1'b1;
    endtask

    initial begin
        int   exp_pops;
        bit   found;
        logic [7:0] pre;
        jitter          = 1'b0;
        n_frames        = 0;
        pops_seen       = 0;
        sh_u            = '0;
        sh_c            = '0;
        rst_n           = 1'b0;
        clk_per_halfbit = '0;
        valid_i         = 1'b1;
        data_l_i        = 24'($urandom);
        data_r_i        = 24'($urandom);
        udata_i         = 192'h1;
        cdata_i         = {1'b1, 191'b0};

        // Power-on reset, then a full block plus a few frames at 1 clk per subbit.
        do_reset(3);
        for (int i = 0; i < 30000 && n_frames < 196; i++) cycle();
        chk("phaseA_frames", 32'(n_frames), 32'd196);
        exp_pops = 0;
        for (int k = 0; k < 196; k++) if (k % 7 != 3) exp_pops++;
        chk("phaseA_pops", 32'(pops_seen), 32'(exp_pops));

        // Random subbit period changes, including mid-subbit.
        clk_per_halfbit = N'(2);
        jitter = 1'b1;
        for (int i = 0; i < 10000 && n_frames < 202; i++) cycle();
        jitter = 1'b0;
        chk("phaseB_frames", 32'(n_frames), 32'd202);

        // Period 0 then 31; then a change during a 32-clock subbit.
        clk_per_halfbit = N'(0);
        repeat (20) cycle();
        clk_per_halfbit = N'(31);
        repeat (200) cycle();
        clk_per_halfbit = N'(2);
        repeat (100) cycle();

        // Reset for one clock in the middle of right-subframe slot 15.
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ((m_sub_g % 128 == 95) && (m_cyc == 1)) begin
                found = 1'b1;
                break;
            end
            cycle();
        end
        chk("reach_slot15", 32'(found), 32'd1);
        clk_per_halfbit = N'(0);
        do_reset(1);
        cycle();
        chk("reset_signal_low", 32'(last_sig), 32'd0);
        pre = '0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            pre = {pre[6:0], last_sig};
        end
        chk("b_preamble_after_reset", 32'(pre), 32'h000000E8);
        repeat (300) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
